// File: rtl/bira_pkg.sv
// Shared sizing defaults and the collector FSM state type for the repair-candidate front end.
package bira_pkg;

  localparam int PCAM      = 8;
  localparam int ADDR_W    = 10;
  localparam int CNT_W     = 3;
  localparam int SPARE_COL = 2;
  localparam int SPARE_ROW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/pcam_entry.sv
// One parent-CAM entry: faulty row address, valid bit, saturating fault count and registered must-repair flag.
module pcam_entry #(
  parameter int ADDR_W    = bira_pkg::ADDR_W,
  parameter int CNT_W     = bira_pkg::CNT_W,
  parameter int SPARE_COL = bira_pkg::SPARE_COL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              alloc_i,
  input  logic              hit_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              vld_o,
  output logic              match_o,
  output logic              must_repair_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(SPARE_COL);

  logic [ADDR_W-1:0] addr_q;
  logic              vld_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              must_q;

  // NOTE: the table lives in flops, so every field takes the async reset and all state uses <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      must_q <= 1'b0;
    end else if (clear_i) begin
      addr_q <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      must_q <= 1'b0;
    end else begin
      // Sampled from the pre-edge count, so the flag trails the crossing accept by one cycle.
      must_q <= vld_q && (cnt_q > THRESH);
      if (alloc_i) begin
        addr_q <= cmp_addr_i;
        vld_q  <= 1'b1;
        cnt_q  <= CNT_W'(1);
      end else if (hit_i && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign addr_o        = addr_q;
  assign vld_o         = vld_q;
  assign match_o       = vld_q && (addr_q == cmp_addr_i);
  assign must_repair_o = must_q;

endmodule

// File: rtl/pcam_fault_collector.sv
// Collects BIST fault rows into a merged parent CAM, flags must-repair rows and freezes the table on bist_done.
module pcam_fault_collector #(
  parameter int PCAM      = bira_pkg::PCAM,
  parameter int ADDR_W    = bira_pkg::ADDR_W,
  parameter int CNT_W     = bira_pkg::CNT_W,
  parameter int SPARE_COL = bira_pkg::SPARE_COL,
  parameter int SPARE_ROW = bira_pkg::SPARE_ROW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   fault_valid,
  input  logic [ADDR_W-1:0]      fault_addr,
  input  logic                   bist_done,
  input  logic                   result_ack,
  output logic                   fault_ready,
  output logic [PCAM*ADDR_W-1:0] pcam_addr,
  output logic [PCAM-1:0]        pcam_vld,
  output logic [PCAM-1:0]        dsss,
  output logic [3:0]             fill_cnt,
  output logic [3:0]             must_cnt,
  output logic                   overflow,
  output logic                   unrepairable,
  output logic                   result_valid
);

  import bira_pkg::*;

  state_e          state_q, state_d;
  logic            rv_q, rv_d;
  logic            overflow_q, overflow_d;
  logic            accept, hit, full;
  logic [PCAM-1:0] vld, match, must, alloc;

  for (genvar g = 0; g < PCAM; g++) begin : g_entry
    pcam_entry #(
      .ADDR_W    (ADDR_W),
      .CNT_W     (CNT_W),
      .SPARE_COL (SPARE_COL)
    ) u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (start),
      .alloc_i       (alloc[g]),
      .hit_i         (accept & match[g]),
      .cmp_addr_i    (fault_addr),
      .addr_o        (pcam_addr[g*ADDR_W +: ADDR_W]),
      .vld_o         (vld[g]),
      .match_o       (match[g]),
      .must_repair_o (must[g])
    );
    // The mux expects entry 0 on the MSB of the must-repair mask.
    assign dsss[PCAM-1-g] = must[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rv_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rv_q       <= rv_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (bist_done) state_d = DONE;
        DONE:    if (result_ack && rv_q) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fault_ready = (state_q == COLLECT);
    accept      = fault_valid && fault_ready && !start;
    hit         = |match;
    full        = &vld;
    // Result is held back one cycle after entering DONE so the registered dsss has settled.
    rv_d        = (state_q == DONE) && (state_d == DONE);
    overflow_d  = !start && (overflow_q || (accept && !hit && full));
  end

  always_comb begin : p_alloc
    logic found;
    found = 1'b0;
    alloc = '0;
    for (int i = 0; i < PCAM; i++) begin
      if (!vld[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!accept || hit) alloc = '0;
  end

  assign pcam_vld     = vld;
  assign fill_cnt     = 4'($countones(vld));
  assign must_cnt     = 4'($countones(dsss));
  assign overflow     = overflow_q;
  assign unrepairable = overflow_q || (must_cnt > 4'(SPARE_ROW));
  assign result_valid = rv_q;

endmodule

// File: tb/tb_pcam_fault_collector.sv
// Self-checking bench for pcam_fault_collector: queue-based table model plus directed scenarios.
module tb_pcam_fault_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        fault_valid = 1'b0;
  logic [9:0]  fault_addr = '0;
  logic        bist_done = 1'b0;
  logic        result_ack = 1'b0;
  logic        fault_ready;
  logic [79:0] pcam_addr;
  logic [7:0]  pcam_vld;
  logic [7:0]  dsss;
  logic [3:0]  fill_cnt;
  logic [3:0]  must_cnt;
  logic        overflow;
  logic        unrepairable;
  logic        result_valid;

  always #5 clk = ~clk;

  pcam_fault_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .fault_valid  (fault_valid),
    .fault_addr   (fault_addr),
    .bist_done    (bist_done),
    .result_ack   (result_ack),
    .fault_ready  (fault_ready),
    .pcam_addr    (pcam_addr),
    .pcam_vld     (pcam_vld),
    .dsss         (dsss),
    .fill_cnt     (fill_cnt),
    .must_cnt     (must_cnt),
    .overflow     (overflow),
    .unrepairable (unrepairable),
    .result_valid (result_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: table is an ordered list of {address, fault count}; entry i is list position i.
  typedef struct {
    logic [9:0] a;
    int         n;
  } ent_t;

  ent_t       tbl[$];
  int         phase    = 0;   // 0 idle, 1 collecting, 2 done
  int         done_age = 0;   // cycles spent in done, saturating at 2
  bit         m_ovf    = 1'b0;
  logic [7:0] m_dsss   = '0;

  task automatic model_step();
    logic [7:0] nd;
    int         idx;
    ent_t       e;
    if (!rst_n) begin
      tbl.delete();
      phase = 0; done_age = 0; m_ovf = 1'b0; m_dsss = '0;
      return;
    end
    nd = '0;
    foreach (tbl[i]) if (tbl[i].n > 2) nd[7-i] = 1'b1;
    if (start) begin
      tbl.delete();
      phase = 1; done_age = 0; m_ovf = 1'b0; m_dsss = '0;
      return;
    end
    m_dsss = nd;
    if (phase == 1) begin
      if (fault_valid) begin
        idx = -1;
        foreach (tbl[i]) if (tbl[i].a == fault_addr) idx = i;
        if (idx >= 0) begin
          e = tbl[idx];
          if (e.n < 7) e.n++;
          tbl[idx] = e;
        end else if (tbl.size() < 8) begin
          e.a = fault_addr; e.n = 1;
          tbl.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (bist_done) begin
        phase = 2; done_age = 1;
      end
    end else if (phase == 2) begin
      if (done_age >= 2 && result_ack) begin
        phase = 0; done_age = 0;
      end else begin
        done_age = 2;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    logic [79:0] ea;
    logic [7:0]  ev;
    int          mc;
    if (cmp_en) begin
      ea = '0; ev = '0;
      foreach (tbl[i]) begin
        ea[i*10 +: 10] = tbl[i].a;
        ev[i] = 1'b1;
      end
      mc = $countones(m_dsss);
      check("m_fault_ready",  80'(fault_ready),  80'(phase == 1));
      check("m_pcam_addr",    pcam_addr,         ea);
      check("m_pcam_vld",     80'(pcam_vld),     80'(ev));
      check("m_dsss",         80'(dsss),         80'(m_dsss));
      check("m_fill_cnt",     80'(fill_cnt),     80'(tbl.size()));
      check("m_must_cnt",     80'(must_cnt),     80'(mc));
      check("m_overflow",     80'(overflow),     80'(m_ovf));
      check("m_unrepairable", 80'(unrepairable), 80'(m_ovf || mc > 4));
      check("m_result_valid", 80'(result_valid), 80'(phase == 2 && done_age >= 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [9:0] a);
    fault_valid = 1'b1;
    fault_addr  = a;
    tick();
    fault_valid = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #6;
    check("rst_fill",   80'(fill_cnt),     80'(0));
    check("rst_vld",    80'(pcam_vld),     80'(0));
    check("rst_addr",   pcam_addr,         80'(0));
    check("rst_ready",  80'(fault_ready),  80'(0));
    check("rst_rv",     80'(result_valid), 80'(0));
    #5 rst_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    // 1: three distinct faults
    pulse_start();
    send(10'h010); send(10'h020); send(10'h030);
    check("t1_fill",   80'(fill_cnt),              80'(3));
    check("t1_vld",    80'(pcam_vld),              80'(8'h07));
    check("t1_entry2", 80'(pcam_addr[20 +: 10]),   80'(10'h030));
    check("t1_dsss",   80'(dsss),                  80'(0));

    // 2: repeated address merges and crosses must-repair threshold one cycle late
    pulse_start();
    send(10'h155); send(10'h155); send(10'h155);
    check("t2_fill",       80'(fill_cnt), 80'(1));
    check("t2_dsss_early", 80'(dsss),     80'(0));
    tick();
    check("t2_dsss",  80'(dsss),     80'(8'h80));
    check("t2_must",  80'(must_cnt), 80'(1));

    // 3: ninth unique address overflows
    pulse_start();
    for (int i = 0; i < 8; i++) send(10'(10'h100 + i));
    check("t3_ovf_before", 80'(overflow), 80'(0));
    send(10'h108);
    check("t3_fill",   80'(fill_cnt),            80'(8));
    check("t3_vld",    80'(pcam_vld),            80'(8'hFF));
    check("t3_entry7", 80'(pcam_addr[70 +: 10]), 80'(10'h107));
    check("t3_ovf",    80'(overflow),            80'(1));
    check("t3_unrep",  80'(unrepairable),        80'(1));

    // 4: five must-repair rows exceed spare rows, four do not
    pulse_start();
    for (int r = 0; r < 5; r++) for (int k = 0; k < 3; k++) send(10'(10'h040 + r));
    tick();
    check("t4a_must",  80'(must_cnt),     80'(5));
    check("t4a_dsss",  80'(dsss),         80'(8'hF8));
    check("t4a_unrep", 80'(unrepairable), 80'(1));
    pulse_start();
    for (int r = 0; r < 4; r++) for (int k = 0; k < 3; k++) send(10'(10'h050 + r));
    tick();
    check("t4b_must",  80'(must_cnt),     80'(4));
    check("t4b_unrep", 80'(unrepairable), 80'(0));

    // 5: fault with bist_done, settle, ack, ignored inputs, restart
    fault_valid = 1'b1; fault_addr = 10'h3FF; bist_done = 1'b1;
    tick();
    fault_valid = 1'b0; bist_done = 1'b0;
    check("t5_ready",  80'(fault_ready),         80'(0));
    check("t5_fill",   80'(fill_cnt),            80'(5));
    check("t5_entry4", 80'(pcam_addr[40 +: 10]), 80'(10'h3FF));
    check("t5_rv0",    80'(result_valid),        80'(0));
    tick();
    check("t5_rv1",    80'(result_valid),        80'(1));
    send(10'h222);
    check("t5_ignored", 80'(fill_cnt), 80'(5));
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("t5_ack_rv",   80'(result_valid), 80'(0));
    check("t5_idle_vld", 80'(pcam_vld),     80'(8'h1F));
    bist_done = 1'b1;
    tick();
    bist_done = 1'b0;
    check("t5_idle_done", 80'(result_valid), 80'(0));
    check("t5_idle_rdy",  80'(fault_ready),  80'(0));
    pulse_start();
    check("t5_restart_fill", 80'(fill_cnt),    80'(0));
    check("t5_restart_rdy",  80'(fault_ready), 80'(1));

    // 6: asynchronous reset mid-collect
    send(10'h001); send(10'h002); send(10'h003); send(10'h004);
    check("t6_fill_pre", 80'(fill_cnt), 80'(4));
    #2 rst_n = 1'b0;
    #1;
    check("t6_fill",  80'(fill_cnt),    80'(0));
    check("t6_vld",   80'(pcam_vld),    80'(0));
    check("t6_addr",  pcam_addr,        80'(0));
    check("t6_ready", 80'(fault_ready), 80'(0));
    #10 rst_n = 1'b1;
    tick();
    tick();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
